// File: rtl/al_alarm_sequencer.sv
// Alarm sequencer.
// Detects the first cycle at which the running time equals the stored alarm
// time and then runs a ring/snooze cycle. The ring stops by auto-off timeout,
// by dismiss, or when the alarm is disabled.
`timescale 1ns/1ps
module al_alarm_sequencer #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 540,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic        clk256,
  input  logic        reset,
  input  logic        one_second,
  input  logic [15:0] current_time,
  input  logic [15:0] alarm_time,
  input  logic        alarm_enable,
  input  logic        snooze,
  input  logic        alarm_off,
  output logic        sound_alarm,
  output logic        snooze_active,
  output logic [1:0]  snooze_left
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  localparam logic [9:0] RING_CNT   = 10'(RING_SECONDS);
  localparam logic [9:0] SNOOZE_CNT = 10'(SNOOZE_SECONDS);
  localparam logic [1:0] SNOOZE_MAX = 2'(MAX_SNOOZE);

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [1:0]  snooze_left_q, snooze_left_d;
  logic        match_q, match_d;
  logic        sound_alarm_q, sound_alarm_d;
  logic        snooze_active_q, snooze_active_d;

  logic        trigger;
  logic [9:0]  cnt_dec;

  // Edge detect on the time match, and a saturating decrement of the counter.
  always_comb begin
    match_d = (current_time == alarm_time);
    trigger = match_d && !match_q;
    cnt_dec = (cnt_q != 10'd0) ? (cnt_q - 10'd1) : cnt_q;
  end

  // Next-state logic; priority: disable > dismiss > snooze > tick expiry.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    snooze_left_d = snooze_left_q;
    case (state_q)
      IDLE: begin
        if (trigger && alarm_enable) begin
          state_d       = RINGING;
          cnt_d         = RING_CNT;
          snooze_left_d = SNOOZE_MAX;
        end
      end
      RINGING: begin
        if (!alarm_enable || alarm_off) begin
          state_d = IDLE;
        end else if (snooze && (snooze_left_q != 2'd0)) begin
          // An accepted snooze swallows a coincident tick.
          state_d       = SNOOZE;
          cnt_d         = SNOOZE_CNT;
          snooze_left_d = snooze_left_q - 2'd1;
        end else if (one_second) begin
          if (cnt_q == 10'd1) begin
            state_d = IDLE;
          end
          cnt_d = cnt_dec;
        end
      end
      SNOOZE: begin
        if (!alarm_enable || alarm_off) begin
          state_d = IDLE;
        end else if (one_second) begin
          if (cnt_q == 10'd1) begin
            state_d = RINGING;
            cnt_d   = RING_CNT;
          end else begin
            cnt_d = cnt_dec;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs are registered copies of the decoded next state.
    sound_alarm_d   = (state_d == RINGING);
    snooze_active_d = (state_d == SNOOZE);
  end

  // State and output registers; match_q resets high so a standing match is not an edge.
  always_ff @(posedge clk256 or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      cnt_q           <= 10'd0;
      snooze_left_q   <= 2'd0;
      match_q         <= 1'b1;
      sound_alarm_q   <= 1'b0;
      snooze_active_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      snooze_left_q   <= snooze_left_d;
      match_q         <= match_d;
      sound_alarm_q   <= sound_alarm_d;
      snooze_active_q <= snooze_active_d;
    end
  end

  assign sound_alarm   = sound_alarm_q;
  assign snooze_active = snooze_active_q;
  assign snooze_left   = snooze_left_q;

endmodule
